// File: rtl/motion_scheduler_pkg.sv
// motion_scheduler_pkg: direction encodings and arbitration FSM states shared with the object host
package motion_scheduler_pkg;
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, ISSUE} state_t;
  function automatic logic dir_valid(input logic [1:0] d);
    return d == DIR_POS || d == DIR_NEG;
  endfunction
endpackage

// File: rtl/motion_scheduler_frame_divider.sv
// frame_divider: counts frame ticks and raises a command slot every FRAME_DIV ticks
module frame_divider #(
  parameter int FRAME_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic clr,
  output logic slot
);
  logic [7:0] cnt;
  logic       wrap;
  always_comb wrap = frame_tick && cnt == 8'(FRAME_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      slot <= 1'b0;
    end else begin
      cnt  <= wrap ? 8'd0 : frame_tick ? cnt + 8'd1 : cnt;
      // a fresh slot landing on the issue edge is a new slot, so set wins
      slot <= wrap ? 1'b1 : clr ? 1'b0 : slot;
    end
  end
endmodule

// File: rtl/motion_scheduler.sv
// motion_scheduler: captures rotate/move requests and issues one arbitrated command per frame slot
module motion_scheduler
  import motion_scheduler_pkg::*;
#(
  parameter int FRAME_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_rotate,
  input  logic [1:0] btn_move,
  input  logic       frame_tick,
  input  logic       render_busy,
  output logic [1:0] rotate,
  output logic [1:0] move,
  output logic [7:0] cmd_count,
  output logic       overrun
);
  state_t     state;
  logic [1:0] rot_pend, mov_pend;
  logic       prio, slot, rot_valid, mov_valid, go, issue, sel_rot, clr_rot, clr_mov, both;
  frame_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .clr(issue), .slot(slot)
  );
  always_comb begin
    rot_valid = dir_valid(btn_rotate);
    mov_valid = dir_valid(btn_move);
    both      = rot_pend != DIR_NONE && mov_pend != DIR_NONE;
    go        = slot && (rot_pend != DIR_NONE || mov_pend != DIR_NONE);
    // issue actions happen on the edge entering ISSUE so the registered output shows during ISSUE
    issue     = !render_busy && ((state == IDLE && go) || state == WAIT_BUSY);
    sel_rot   = rot_pend != DIR_NONE && (mov_pend == DIR_NONE || !prio);
    clr_rot   = issue && sel_rot;
    clr_mov   = issue && !sel_rot;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rot_pend  <= DIR_NONE;
      mov_pend  <= DIR_NONE;
      prio      <= 1'b0;
      rotate    <= DIR_NONE;
      move      <= DIR_NONE;
      cmd_count <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= issue ? ISSUE : (state == IDLE && go) ? WAIT_BUSY : state == ISSUE ? IDLE : state;
      rotate    <= clr_rot ? rot_pend : DIR_NONE;
      move      <= clr_mov ? mov_pend : DIR_NONE;
      rot_pend  <= rot_valid ? btn_rotate : clr_rot ? DIR_NONE : rot_pend;
      mov_pend  <= mov_valid ? btn_move : clr_mov ? DIR_NONE : mov_pend;
      cmd_count <= issue ? cmd_count + 8'd1 : cmd_count;
      prio      <= (issue && both) ? ~prio : prio;
      overrun   <= overrun
                 | (rot_valid && rot_pend != DIR_NONE && btn_rotate != rot_pend && !clr_rot)
                 | (mov_valid && mov_pend != DIR_NONE && btn_move != mov_pend && !clr_mov);
    end
  end
endmodule

// File: tb/tb_motion_scheduler.sv
// tb_motion_scheduler: vector table plus directed sequences for reset, capture, round-robin and wrap
module tb_motion_scheduler;
  logic       clk = 0, rst = 0, frame_tick = 0, render_busy = 0;
  logic [1:0] btn_rotate = 0, btn_move = 0, rotate, move;
  logic [7:0] cmd_count;
  logic       overrun;
  int         passed = 0, total = 0, both_hits = 0;
  typedef struct {
    logic       r;
    logic [1:0] rot, mov;
    logic       tick, busy;
    logic [1:0] e_rot, e_mov;
    logic [7:0] e_cnt;
    logic       e_ov;
  } vec_t;
  vec_t vec[$];
  motion_scheduler #(.FRAME_DIV(4)) dut (
    .clk(clk), .rst(rst), .btn_rotate(btn_rotate), .btn_move(btn_move),
    .frame_tick(frame_tick), .render_busy(render_busy),
    .rotate(rotate), .move(move), .cmd_count(cmd_count), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rotate != 2'b00 && move != 2'b00) both_hits++;
  task automatic step(input logic r, input logic [1:0] rt, input logic [1:0] mv, input logic t, input logic b);
    rst = r; btn_rotate = rt; btn_move = mv; frame_tick = t; render_busy = b;
    @(posedge clk);
    #1;
    rst = 0; btn_rotate = 0; btn_move = 0; frame_tick = 0; render_busy = 0;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic void add(input logic r, input logic [1:0] rt, input logic [1:0] mv, input logic t,
                              input logic b, input logic [1:0] er, input logic [1:0] em,
                              input logic [7:0] ec, input logic eo, input int n);
    for (int k = 0; k < n; k++) vec.push_back('{r, rt, mv, t, b, er, em, ec, eo});
  endfunction
  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 2, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 2, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 0, 1, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 2, 0, 4);
    add(0, 0, 0, 0, 0, 0, 2, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 3, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 3, 1, 1);
    add(0, 3, 0, 0, 0, 0, 0, 3, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 3, 1, 4);
    add(0, 0, 0, 0, 0, 2, 0, 4, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 4, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 4, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 4, 1, 4);
    add(0, 0, 0, 0, 1, 0, 0, 4, 1, 10);
    add(0, 0, 0, 0, 0, 0, 1, 5, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 5, 1, 1);
    @(negedge clk);
    foreach (vec[i]) begin
      step(vec[i].r, vec[i].rot, vec[i].mov, vec[i].tick, vec[i].busy);
      chk($sformatf("vec%0d", i), {rotate, move, cmd_count, overrun},
          {vec[i].e_rot, vec[i].e_mov, vec[i].e_cnt, vec[i].e_ov});
    end
    // reset in the ISSUE cycle, with a request in the reset cycle that must be dropped
    step(1, 0, 0, 0, 0);
    step(0, 0, 2, 0, 0);
    ticks(4);
    step(0, 0, 0, 0, 0);
    chk("rst_pre_issue", {rotate, move, cmd_count}, {2'b00, 2'b10, 8'd1});
    step(1, 1, 0, 0, 0);
    chk("rst_in_issue", {rotate, move, cmd_count, overrun}, {2'b00, 2'b00, 8'd0, 1'b0});
    ticks(4);
    step(0, 0, 0, 0, 0);
    chk("rst_pend_clear", {rotate, move, cmd_count}, {2'b00, 2'b00, 8'd0});
    // capture on the issue edge takes precedence over the clear
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    ticks(4);
    step(0, 1, 0, 0, 0);
    chk("cap_issue", {rotate, move, cmd_count}, {2'b01, 2'b00, 8'd1});
    ticks(4);
    step(0, 0, 0, 0, 0);
    chk("cap_retained", {rotate, move, cmd_count, overrun}, {2'b01, 2'b00, 8'd2, 1'b0});
    // round-robin: priority flips after a contested issue
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    ticks(4);
    step(0, 0, 0, 0, 0);
    chk("rr_first_rot", {rotate, move}, {2'b01, 2'b00});
    step(0, 2, 0, 0, 0);
    ticks(4);
    step(0, 0, 0, 0, 0);
    chk("rr_then_mov", {rotate, move}, {2'b00, 2'b01});
    ticks(4);
    step(0, 0, 0, 0, 0);
    chk("rr_then_rot", {rotate, move, cmd_count}, {2'b10, 2'b00, 8'd3});
    // cmd_count wrap
    step(1, 0, 0, 0, 0);
    for (int n = 1; n <= 256; n++) begin
      step(0, 1, 0, 0, 0);
      ticks(4);
      step(0, 0, 0, 0, 0);
      if (n == 255) chk("cnt_255", cmd_count, 8'd255);
    end
    chk("cnt_wrap", cmd_count, 8'd0);
    chk("never_both", both_hits, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/motion_scheduler.md
MOTION_SCHEDULER -- requirements
Module: motion_scheduler

Interface
REQ-001 Parameter FRAME_DIV, default 4: frame_tick pulses per command slot; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 btn_rotate  input  2  raw rotate request; 01 = right, 10 = left, 00/11 = none.
REQ-005 btn_move  input  2  raw move request; 01 = backward, 10 = forward, 00/11 = none.
REQ-006 frame_tick  input  1  one-cycle pulse per displayed frame.
REQ-007 render_busy  input  1  high while the renderer reads the object bus; no player update is issued while high.
REQ-008 rotate  output  2  one-cycle rotate command to the object host.
REQ-009 move  output  2  one-cycle move command to the object host.
REQ-010 cmd_count  output  8  number of commands issued; wraps 255 -> 0.
REQ-011 overrun  output  1  sticky flag; set when a pending request is replaced by a different valid code before issue.

Function
REQ-012 Pending registers rot_pend[1:0] and mov_pend[1:0] capture any valid input code (01/10) every cycle; 00 and 11 never modify pending state.
REQ-013 A valid code differing from a nonzero pending value of the same class replaces it and sets overrun; an identical code is a no-op.
REQ-014 Frame counter counts frame_tick pulses 0..FRAME_DIV-1; on the tick that wraps it to 0, the slot flag is set.
REQ-015 FSM states: IDLE, WAIT_BUSY, ISSUE.
REQ-016 IDLE -> ISSUE when slot = 1, at least one pending register is nonzero, and render_busy = 0.
REQ-017 IDLE -> WAIT_BUSY when slot = 1, a request is pending, and render_busy = 1; WAIT_BUSY -> ISSUE on the first cycle render_busy = 0.
REQ-018 ISSUE lasts exactly one cycle and returns to IDLE: it drives the selected class output with its pending code, clears that pending register, clears slot, and increments cmd_count.
REQ-019 Outputs are registered: the command appears on rotate/move during the ISSUE cycle and is 00 in every other cycle.
REQ-020 rotate and move are never nonzero in the same cycle.
REQ-021 Arbitration is round-robin: a 1-bit priority register (0 = rotate first) toggles after each issue in which both classes were pending; with one class pending, that class is chosen and priority is unchanged.
REQ-022 A request captured in the ISSUE cycle for the class being cleared is retained; capture has precedence over clear.
REQ-023 A slot with no pending request stays set until a request arrives; slots do not accumulate, so at most one command is issued per set slot.
REQ-024 A frame_tick arriving in any state still advances the frame counter.
REQ-025 Minimum latency is 2 cycles: request at edge t -> pending at t+1 -> ISSUE output at t+2, given slot set and render_busy = 0.

Reset
REQ-026 While rst = 1 at a clock edge: FSM = IDLE; pending registers, slot, priority, and frame counter = 0; rotate = move = 00; cmd_count = 0; overrun = 0.
REQ-027 Reset during ISSUE or WAIT_BUSY aborts the command, with no pulse in the following cycle.
REQ-028 Inputs sampled in the reset cycle are discarded.

Structure
REQ-029 A shared package holds the direction encodings (DIR_NONE = 00, DIR_POS = 01, DIR_NEG = 10) and the FSM state enumeration; the object host uses the same encodings.
REQ-030 One sub-module, frame_divider, holds the frame counter and slot flag; the arbitration FSM stays in motion_scheduler.

Verification
REQ-031 Scenario: FRAME_DIV = 4, btn_move = 10 for one cycle, then 4 frame_ticks -> move = 10 for exactly one cycle after the 4th tick, and cmd_count = 1.
REQ-032 Scenario: btn_rotate = 01 and btn_move = 10 in the same cycle, slot set, priority 0 -> rotate = 01 issued first and move = 10 in the next slot; never both nonzero.
REQ-033 Scenario: slot set, render_busy held high for 10 cycles -> FSM stays in WAIT_BUSY, outputs 00; command issued the cycle after render_busy falls.
REQ-034 Scenario: btn_rotate = 01, then 10 before any slot -> rotate = 10 issued and overrun = 1; btn_rotate = 11 alone changes nothing.
REQ-035 Scenario: rst asserted in the ISSUE cycle -> next cycle outputs 00, cmd_count = 0, pending cleared; 256 issued commands -> cmd_count wraps to 0.
